// File: rtl/word_narrower_if.sv
// Handshake bundle for word_narrower: wide-word input stream and narrow-chunk output stream.
// master = producer/consumer side (bench), slave = the narrowing unit.
interface word_narrower_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_split;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_trunc_err;

  modport master (
    output in_valid, in_data, in_split, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_trunc_err
  );

  modport slave (
    input  in_valid, in_data, in_split, out_ready,
    output in_ready, out_valid, out_data, out_last, out_trunc_err
  );
endinterface

// File: rtl/word_narrower.sv
// Splits a wide word into LSB-first chunks, or truncates it to the low chunk with an overflow flag.
// Define NARROW_SIGNED_CHECK_EN to make the truncate flag a signed-overflow check instead of zero-extension.
module word_narrower #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  word_narrower_if.slave  bus
);

  localparam int NCHUNK = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W  = $clog2(NCHUNK);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]           state_q;
  logic [IN_WIDTH-1:0]  word_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic                 out_last_q;
  logic                 err_q;
  logic                 accept;
  logic [OUT_WIDTH-1:0] chunk [NCHUNK];

  // Flag set when the low chunk alone cannot represent the word.
  function automatic logic trunc_err(input logic [IN_WIDTH-1:0] w);
`ifdef NARROW_SIGNED_CHECK_EN
    logic signed [IN_WIDTH-1:0] t;
    t = $signed(w) >>> (OUT_WIDTH - 1);
    return (t != '0) && (t != '1);
`else
    return (w >> OUT_WIDTH) != '0;
`endif
  endfunction

  for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
    assign chunk[k] = word_q[k*OUT_WIDTH +: OUT_WIDTH];
  end

  // Accept on the final-beat edge too, so consecutive words stream without a bubble.
  assign bus.in_ready = (state_q == IDLE) ||
                        ((state_q == EMIT) && bus.out_ready && out_last_q);
  assign accept       = bus.in_valid && bus.in_ready;
  assign cnt_nxt      = cnt_q + 1'b1;

  assign bus.out_valid     = (state_q == EMIT);
  assign bus.out_data      = out_data_q;
  assign bus.out_last      = out_last_q;
  assign bus.out_trunc_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (accept) begin
      state_q    <= EMIT;
      word_q     <= bus.in_data;
      cnt_q      <= '0;
      out_data_q <= bus.in_data[OUT_WIDTH-1:0];
      out_last_q <= !bus.in_split;
      err_q      <= !bus.in_split && trunc_err(bus.in_data);
    end else if ((state_q == EMIT) && bus.out_ready) begin
      if (!out_last_q) begin
        cnt_q      <= cnt_nxt;
        out_data_q <= chunk[cnt_nxt];
        out_last_q <= (cnt_nxt == CNT_W'(NCHUNK - 1));
      end else begin
        state_q    <= IDLE;
        out_last_q <= 1'b0;
        err_q      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_word_narrower.sv
// Directed + randomized bench for word_narrower with a queue-based reference model of the beat stream.
module tb_word_narrower;

  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int NCH   = IN_W / OUT_W;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
    logic             err;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rand_rdy = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_beats = 0;
  beat_t exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  word_narrower_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

  word_narrower #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [IN_W-1:0] d);
`ifdef NARROW_SIGNED_CHECK_EN
    int v;
    v = int'($signed(d));
    return (v < -(1 << (OUT_W - 1))) || (v >= (1 << (OUT_W - 1)));
`else
    return int'(d) >= (1 << OUT_W);
`endif
  endfunction

  function automatic void push_model(input logic [IN_W-1:0] d, input logic s);
    beat_t b;
    if (s) begin
      for (int k = 0; k < NCH; k++) begin
        b.data = OUT_W'(d >> (k * OUT_W));
        b.last = (k == NCH - 1);
        b.err  = 1'b0;
        exp_q.push_back(b);
      end
    end else begin
      b.data = OUT_W'(d);
      b.last = 1'b1;
      b.err  = exp_err(d);
      exp_q.push_back(b);
    end
  endfunction

  // Every transferred output beat is compared against the model stream.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        chk("out_last", 32'(bus.out_last), 32'(e.last));
        chk("out_trunc_err", 32'(bus.out_trunc_err), 32'(e.err));
      end
      n_beats++;
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [IN_W-1:0] d, input logic s, output int acc_cyc);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_split = s;
    acc_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_model(d, s);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        break;
      end
    end
    chk("accept_timeout", 32'(acc_cyc >= 0), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c1, c2, b0, dr;
    logic [IN_W-1:0] d;
    logic [OUT_W-1:0] lo;
    logic s;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_split  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_trunc_err", 32'(bus.out_trunc_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Split A55A
    bus.out_ready = 1'b1;
    send(16'hA55A, 1'b1, c1);
    bus.in_valid = 1'b0;
    chk("split_first_data", 32'(bus.out_data), 32'h5A);
    chk("split_first_last", 32'(bus.out_last), 32'd0);
    idle(3);

    // Truncate without and with upper bits
    send(16'h004C, 1'b0, c1);
    bus.in_valid = 1'b0;
    chk("trunc_data", 32'(bus.out_data), 32'h4C);
    chk("trunc_last", 32'(bus.out_last), 32'd1);
    chk("trunc_err_clear", 32'(bus.out_trunc_err), 32'd0);
    idle(2);
    send(16'h014C, 1'b0, c1);
    bus.in_valid = 1'b0;
    chk("trunc_err_set", 32'(bus.out_trunc_err), 32'd1);
    idle(2);
    send(16'hFF80, 1'b0, c1);
    bus.in_valid = 1'b0;
`ifdef NARROW_SIGNED_CHECK_EN
    chk("trunc_ff80", 32'(bus.out_trunc_err), 32'd0);
`else
    chk("trunc_ff80", 32'(bus.out_trunc_err), 32'd1);
`endif
    idle(2);
    send(16'h0080, 1'b0, c1);
    bus.in_valid = 1'b0;
`ifdef NARROW_SIGNED_CHECK_EN
    chk("trunc_0080", 32'(bus.out_trunc_err), 32'd1);
`else
    chk("trunc_0080", 32'(bus.out_trunc_err), 32'd0);
`endif
    idle(2);

    // Backpressure on each beat of 1234
    bus.out_ready = 1'b0;
    b0 = n_beats;
    send(16'h1234, 1'b1, c1);
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold0_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold0_data", 32'(bus.out_data), 32'h34);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold1_data", 32'(bus.out_data), 32'h12);
      chk("bp_hold1_last", 32'(bus.out_last), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_done_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_beat_count", 32'(n_beats - b0), 32'd2);
    @(posedge clk);
    #1;

    // Back-to-back words, second accepted on the last-beat edge
    send(16'h1111, 1'b1, c1);
    send(16'h2200, 1'b0, c2);
    bus.in_valid = 1'b0;
    chk("b2b_gap", 32'(c2 - c1), 32'd2);
    chk("b2b_second_data", 32'(bus.out_data), 32'h00);
    chk("b2b_second_err", 32'(bus.out_trunc_err), 32'd1);
    idle(3);

    // Reset after the first beat of BEEF
    bus.out_ready = 1'b0;
    send(16'hBEEF, 1'b1, c1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_last", 32'(bus.out_last), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    d = 16'($urandom);
    lo = d[OUT_W-1:0];
    send(d, 1'b1, c1);
    bus.in_valid = 1'b0;
    chk("after_rst_low_chunk", 32'(bus.out_data), 32'(lo));
    idle(3);

    // Randomized words with random backpressure and gaps
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = {8'hFF, d[7:0]};
      s = 1'($urandom_range(0, 1));
      send(d, s, c1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    bus.in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    dr = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && dr < 100) begin
      @(posedge clk);
      #1;
      dr++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
